// File: rtl/refill_responder.sv
// refill_responder: memory-side responder for ICache line refills, plus its beat buffer.
// Optional feature macro: REFILL_CRITICAL_WORD_FIRST_EN (critical-word-first, wrapping beat order).
// With the macro undefined, beats always return in ascending word order from the line base.

// Purpose: small synchronous in-order FIFO used as the refill beat buffer.
// Latency: a push is visible at the head the cycle after it is written (registered occupancy).
// Backpressure: none on push (caller guarantees space); head holds still until pop_rdy.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_hs;

    assign pop_vld = (count_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign pop_hs  = pop_vld && pop_rdy;

    // Pointer and occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_vld, pop_hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// Purpose: accepts one acquire, issues BEATS word reads, streams buffered words back as grant beats.
// Latency: first grant beat at acquire + 2 + memory latency, then one beat per cycle; idle the cycle after the last beat.
// Backpressure: requests wait on mem_req_ready; grant beats hold on grant_ready while the buffer absorbs all BEATS responses.
module refill_responder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acquire_valid,
    output logic              acquire_ready,
    input  logic [ADDR_W-1:0] acquire_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              grant_valid,
    input  logic              grant_ready,
    output logic [DATA_W-1:0] grant_data,
    output logic [BEAT_W-1:0] grant_beat,
    output logic              grant_last
);
    localparam int unsigned WB       = DATA_W / 8;
    localparam int unsigned WB_LOG   = $clog2(WB);
    localparam int unsigned LINE_LOG = $clog2(BEATS * WB);
    localparam int unsigned CNT_W    = BEAT_W + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BEATS * WB - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BEAT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0]  ic_q, ic_d;
    logic [CNT_W-1:0]  gc_q, gc_d;
    logic              acq_rdy_q, acq_rdy_d;

    logic              acq_hs;
    logic              mem_req_hs;
    logic              grant_hs;
    logic              resp_push_vld;
    logic [BEAT_W-1:0] issue_word;
    logic [BEAT_W-1:0] grant_word;

    assign acq_hs     = acquire_valid && acq_rdy_q;
    assign mem_req_hs = mem_req_valid && mem_req_ready;
    assign grant_hs   = grant_valid && grant_ready;

    // Word order is a BEAT_W-bit wrap from the latched start word.
    assign issue_word = start_q + ic_q[BEAT_W-1:0];
    assign grant_word = start_q + gc_q[BEAT_W-1:0];

    assign acquire_ready = acq_rdy_q;
    assign mem_req_valid = (state_q == ST_BUSY) && (ic_q < CNT_W'(BEATS));
    assign mem_req_addr  = base_q + (ADDR_W'(issue_word) << WB_LOG);
    assign grant_beat    = grant_word;
    assign grant_last    = (state_q == ST_BUSY) && (gc_q == CNT_W'(BEATS - 1));

    // Stray responses arriving while idle (e.g. after a mid-line reset) are dropped here.
    assign resp_push_vld = mem_resp_valid && (state_q == ST_BUSY);

    // Beat buffer: one slot per beat, so in-flight plus buffered words can never overflow it.
    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (BEATS)
    ) u_beat_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (resp_push_vld),
        .push_dat (mem_resp_data),
        .pop_vld  (grant_valid),
        .pop_rdy  (grant_ready),
        .pop_dat  (grant_data)
    );

    // Next-state logic: latch the line on acquire, count issued and granted beats, finish on the last grant.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        start_d = start_q;
        ic_d    = ic_q;
        gc_d    = gc_q;
        case (state_q)
            ST_IDLE: begin
                if (acq_hs) begin
                    state_d = ST_BUSY;
                    base_d  = acquire_addr & ~OFF_MASK;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
                    start_d = acquire_addr[LINE_LOG-1:WB_LOG];
`else
                    start_d = '0;
`endif
                    ic_d    = '0;
                    gc_d    = '0;
                end
            end
            ST_BUSY: begin
                if (mem_req_hs) begin
                    ic_d = ic_q + CNT_W'(1);
                end
                if (grant_hs) begin
                    gc_d = gc_q + CNT_W'(1);
                end
                if (grant_hs && grant_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // acquire_ready is registered so it reads 0 during reset and rises the cycle after the last beat.
        acq_rdy_d = (state_d == ST_IDLE);
    end

    // State registers with synchronous reset; reset drops any line in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            start_q   <= '0;
            ic_q      <= '0;
            gc_q      <= '0;
            acq_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            start_q   <= start_d;
            ic_q      <= ic_d;
            gc_q      <= gc_d;
            acq_rdy_q <= acq_rdy_d;
        end
    end
endmodule
